serial_magnitude_comparator: RTL and testbench

Multi-cycle magnitude comparator that evaluates two WIDTH-bit operands MSB-first, DIGIT bits per cycle. The greater/less/equal state is carried from one digit to the next in internal registers. Unsigned and two's-complement modes are supported, with a start/done handshake. It is the sequential, width-parametrised successor of the single-bit cascaded comparator stage. It sits in the datapath wherever a compare result may take several cycles to produce.

---
 rtl/serial_magnitude_comparator_if.sv | 25 ++
 rtl/serial_magnitude_comparator.sv | 108 ++++++++++
 tb/tb_serial_magnitude_comparator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// Handshake, operand and result bundle for serial_magnitude_comparator.
// The requester uses the master modport; the comparator uses slave.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             greater;
  logic             less;
  logic             equal;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, greater, less, equal
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, greater, less, equal
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first digit-serial magnitude comparator, unsigned or two's-complement.
// Optional SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing digit.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  serial_magnitude_comparator_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start; result outputs hold the last compare
  // RUN   | one digit of A and B compared per cycle, MSB first
  // DONE  | one-cycle done pulse; result already loaded
  localparam int ND = WIDTH / DIGIT;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(ND - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sign_flip;
  logic [CW-1:0]    digit_cnt;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             run_g, run_l, run_eq;
  logic             g_nxt, l_nxt, eq_nxt;
  logic             res_g, res_l, res_eq;
  logic             accept;
  logic             last_step;

  assign accept = (state == IDLE) && bus.start;

  // Inverting both MSBs maps two's-complement order onto unsigned order.
  assign sign_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};

  assign dig_a  = sh_a[WIDTH-1 -: DIGIT];
  assign dig_b  = sh_b[WIDTH-1 -: DIGIT];
  assign g_nxt  = run_g | (run_eq & (dig_a > dig_b));
  assign l_nxt  = run_l | (run_eq & (dig_a < dig_b));
  assign eq_nxt = run_eq & (dig_a == dig_b);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign last_step = (digit_cnt == LAST_DIGIT) || !eq_nxt;
`else
  assign last_step = (digit_cnt == LAST_DIGIT);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a      <= '0;
      sh_b      <= '0;
      digit_cnt <= '0;
      run_g     <= 1'b0;
      run_l     <= 1'b0;
      run_eq    <= 1'b0;
      res_g     <= 1'b0;
      res_l     <= 1'b0;
      res_eq    <= 1'b0;
    end else if (accept) begin
      sh_a      <= bus.a ^ sign_flip;
      sh_b      <= bus.b ^ sign_flip;
      digit_cnt <= '0;
      run_g     <= 1'b0;
      run_l     <= 1'b0;
      run_eq    <= 1'b1;
    end else if (state == RUN) begin
      sh_a      <= sh_a << DIGIT;
      sh_b      <= sh_b << DIGIT;
      digit_cnt <= digit_cnt + CW'(1);
      run_g     <= g_nxt;
      run_l     <= l_nxt;
      run_eq    <= eq_nxt;
      if (last_step) begin
        res_g  <= g_nxt;
        res_l  <= l_nxt;
        res_eq <= eq_nxt;
      end
    end
  end

  assign bus.greater = res_g;
  assign bus.less    = res_l;
  assign bus.equal   = res_eq;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized bench for serial_magnitude_comparator (8-bit/2-bit digits and 16-bit single digit),
// checked against an arithmetic reference model.
module tb_serial_magnitude_comparator;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(8))  bus8 ();
  serial_magnitude_comparator_if #(.WIDTH(16)) bus16 ();

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave)
  );
  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: integer compare plus latency from the highest differing bit.
  function automatic void ref_cmp(input int w, input int dig, input logic [15:0] a,
                                  input logic [15:0] b, input logic sm,
                                  output logic [2:0] gle, output int lat);
    longint va, vb;
    int     hb;
    va = longint'(a);
    vb = longint'(b);
    if (sm && a[w-1]) va = va - (longint'(1) << w);
    if (sm && b[w-1]) vb = vb - (longint'(1) << w);
    gle = {va > vb, va < vb, va == vb};
    lat = w / dig;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    hb = -1;
    for (int i = w - 1; i >= 0; i--)
      if (hb < 0 && a[i] != b[i]) hb = i;
    if (hb >= 0) lat = (w - 1 - hb) / dig + 1;
`else
    hb = 0;
`endif
  endfunction

  task automatic cmp8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sm);
    logic [2:0] egle;
    int         elat;
    int         k;
    ref_cmp(8, 2, {8'h00, a}, {8'h00, b}, sm, egle, elat);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.signed_mode = sm;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.signed_mode = 1'($urandom);
    check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
    k = 0;
    while (!bus8.done && k < ND + 3) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(elat));
    check({tag, "_res"}, {28'd0, bus8.busy, bus8.greater, bus8.less, bus8.equal}, {28'd0, 1'b1, egle});
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, bus8.busy, bus8.done}, 32'd0);
  endtask

  task automatic cmp16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sm);
    logic [2:0] egle;
    int         elat;
    int         k;
    ref_cmp(16, 16, a, b, sm, egle, elat);
    @(negedge clk);
    bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.signed_mode = sm;
    @(posedge clk); #1;
    bus16.start = 1'b0; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    k = 0;
    while (!bus16.done && k < 4) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(elat));
    check({tag, "_res"}, {29'd0, bus16.greater, bus16.less, bus16.equal}, {29'd0, egle});
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] egle;
    int         elat, k, dl, acc, ndone;
    logic       seen_idle;

    reset = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.signed_mode = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check("reset8", {27'd0, bus8.busy, bus8.done, bus8.greater, bus8.less, bus8.equal}, 32'd0);
    check("reset16", {27'd0, bus16.busy, bus16.done, bus16.greater, bus16.less, bus16.equal}, 32'd0);

    // reset and start on the same edge
    @(negedge clk);
    reset = 1'b1; bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02;
    @(posedge clk); #1;
    check("rst_vs_start", 32'(bus8.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0; bus8.start = 1'b0;

    cmp8("lowdig", 8'h12, 8'h11, 1'b0);
    cmp8("c0_uns", 8'hC0, 8'h40, 1'b0);
    cmp8("c0_sgn", 8'hC0, 8'h40, 1'b1);
    cmp8("sgn_ext", 8'h80, 8'h7F, 1'b1);
    cmp8("uns_ext", 8'h80, 8'h7F, 1'b0);
    cmp8("eq_a5", 8'hA5, 8'hA5, 1'b0);

    // start held high: re-accept exactly ND+2 cycles after the first
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hA5; bus8.b = 8'hA5; bus8.signed_mode = 1'b0;
    @(posedge clk); #1;
    k = 0; dl = 0; acc = 0; seen_idle = 1'b0;
    while (acc == 0 && k < 12) begin
      @(posedge clk); #1;
      k++;
      if (bus8.done && dl == 0) begin
        dl = k;
        check("hold_res", {29'd0, bus8.greater, bus8.less, bus8.equal}, 32'd1);
      end
      if (!bus8.busy) seen_idle = 1'b1;
      else if (seen_idle) acc = k;
    end
    check("hold_lat", 32'(dl), 32'd4);
    check("hold_respace", 32'(acc), 32'd6);
    @(negedge clk) bus8.start = 1'b0;
    k = 0;
    while (bus8.busy && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("hold_drain", 32'(bus8.busy), 32'd0);

    // start while busy is ignored
    ref_cmp(8, 2, 16'h0001, 16'h0002, 1'b0, egle, elat);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.signed_mode = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00; bus8.signed_mode = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    k = 2;
    while (!bus8.done && k < ND + 4) begin
      @(posedge clk); #1;
      k++;
    end
    check("ign_lat", 32'(k), 32'(elat));
    check("ign_res", {29'd0, bus8.greater, bus8.less, bus8.equal}, {29'd0, egle});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ign_no_requeue", 32'(bus8.busy), 32'd0);

    // reset mid-run: back to IDLE, results cleared, no done pulse
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h11; bus8.signed_mode = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("midrun_rst", {27'd0, bus8.busy, bus8.done, bus8.greater, bus8.less, bus8.equal}, 32'd0);
    @(negedge clk) reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus8.done) ndone++;
    end
    check("midrun_nodone", 32'(ndone), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ 8'(1 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      cmp8($sformatf("rnd%0d", i), ra, rb, 1'($urandom));
    end

    cmp16("w16_sgn", 16'h8000, 16'h0001, 1'b1);
    cmp16("w16_uns", 16'h8000, 16'h0001, 1'b0);
    cmp16("w16_eq", 16'h1234, 16'h1234, 1'b1);
    for (int i = 0; i < 6; i++)
      cmp16($sformatf("w16_rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
